// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, operation/state encodings and the read-modify-write helper.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTIE_BIT = 7;
  localparam int MEIE_BIT = 11;

  typedef enum logic [1:0] {
    NOP = 2'b00,
    RW  = 2'b01,
    RS  = 2'b10,
    RC  = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    RET   = 2'd2,
    SLEEP = 2'd3
  } csr_state_e;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      RW:      return wdata;
      RS:      return old_val | wdata;
      RC:      return old_val & ~wdata;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter split into 32-bit halves; the high word only
// moves when the low word wraps, so a same-cycle read sees the old high word.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (en) begin
      lo_d = lo_q + 32'd1;
      if (lo_q == 32'hFFFF_FFFF) begin
        hi_d = hi_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign lo = lo_q;
  assign hi = hi_q;

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file, counters and trap/return/sleep sequencer beside EXE.
// Define CSR_IRQ_SYNC_EN to pass ext_irq/timer_irq through 2-flop synchronizers.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_BASE = 32'h0001_0000,
  parameter int          XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            mret,
  input  logic            wfi,
  input  logic            ext_irq,
  input  logic            timer_irq,
  input  logic [XLEN-1:0] pc_exe,
  input  logic            retire,
  input  logic            pipe_stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            wfi_stall
);

  logic ext_s, tmr_s;

`ifdef CSR_IRQ_SYNC_EN
  logic [1:0] ext_sync_q, ext_sync_d;
  logic [1:0] tmr_sync_q, tmr_sync_d;

  always_comb begin
    ext_sync_d = {ext_sync_q[0], ext_irq};
    tmr_sync_d = {tmr_sync_q[0], timer_irq};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_sync_q <= '0;
      tmr_sync_q <= '0;
    end else begin
      ext_sync_q <= ext_sync_d;
      tmr_sync_q <= tmr_sync_d;
    end
  end

  assign ext_s = ext_sync_q[1];
  assign tmr_s = tmr_sync_q[1];
`else
  assign ext_s = ext_irq;
  assign tmr_s = timer_irq;
`endif

  logic [31:0] cycle_lo, cycle_hi, instret_lo, instret_hi;

  csr_counter64 u_cycle (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .lo  (cycle_lo),
    .hi  (cycle_hi)
  );

  csr_counter64 u_instret (
    .clk (clk),
    .rst (rst),
    .en  (retire && !pipe_stall),
    .lo  (instret_lo),
    .hi  (instret_hi)
  );

  csr_state_e  state_q, state_d;
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic        mtie_q, mtie_d, meie_q, meie_d;
  logic [31:0] mepc_q, mepc_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        wfi_stall_q, wfi_stall_d;

  logic        irq_wake, irq_pend, csr_we;
  logic [31:0] csr_new;
  csr_op_e     op;

  assign op       = csr_op_e'(csr_op);
  // Wake ignores the global MIE so WFI can resume with interrupts masked.
  assign irq_wake = (ext_s && meie_q) || (tmr_s && mtie_q);
  assign irq_pend = mie_q && irq_wake;
  assign csr_we   = csr_en && (op != NOP) && !pipe_stall && (state_q == IDLE) && !irq_pend;
  assign csr_new  = csr_apply(op, csr_rdata, csr_wdata);

  always_comb begin
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      CSR_MIE:      csr_rdata = {20'd0, meie_q, 3'd0, mtie_q, 7'd0};
      CSR_MTVEC:    csr_rdata = MTVEC_BASE;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MIP:      csr_rdata = {20'd0, ext_s, 3'd0, tmr_s, 7'd0};
      CSR_CYCLE:    csr_rdata = cycle_lo;
      CSR_CYCLEH:   csr_rdata = cycle_hi;
      CSR_INSTRET:  csr_rdata = instret_lo;
      CSR_INSTRETH: csr_rdata = instret_hi;
      default:      csr_rdata = '0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    mie_d            = mie_q;
    mpie_d           = mpie_q;
    mtie_d           = mtie_q;
    meie_d           = meie_q;
    mepc_d           = mepc_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    wfi_stall_d      = wfi_stall_q;

    if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_d  = csr_new[MIE_BIT];
          mpie_d = csr_new[MPIE_BIT];
        end
        CSR_MIE: begin
          mtie_d = csr_new[MTIE_BIT];
          meie_d = csr_new[MEIE_BIT];
        end
        CSR_MEPC: mepc_d = csr_new & ~32'h3;
        default:  ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (!pipe_stall) begin
          if (irq_pend) begin
            state_d          = TRAP;
            mepc_d           = pc_exe & ~32'h3;
            mpie_d           = mie_q;
            mie_d            = 1'b0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = MTVEC_BASE;
          end else if (mret) begin
            state_d          = RET;
            mie_d            = mpie_q;
            mpie_d           = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mepc_q;
          end else if (wfi) begin
            state_d     = SLEEP;
            wfi_stall_d = 1'b1;
          end
        end
      end
      TRAP, RET: state_d = IDLE;
      SLEEP: begin
        if (irq_wake) begin
          state_d     = IDLE;
          wfi_stall_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mtie_q           <= 1'b0;
      meie_q           <= 1'b0;
      mepc_q           <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      wfi_stall_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      mie_q            <= mie_d;
      mpie_q           <= mpie_d;
      mtie_q           <= mtie_d;
      meie_q           <= meie_d;
      mepc_q           <= mepc_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      wfi_stall_q      <= wfi_stall_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush          = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign wfi_stall      = wfi_stall_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed scenarios followed by
// randomized traffic compared against an architectural model of the CSR file.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_en, mret, wfi, ext_irq, timer_irq, retire, pipe_stall;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, pc_exe;
  logic [31:0] csr_rdata, redirect_pc;
  logic        redirect_valid, flush, wfi_stall;

  always #5 clk = ~clk;

  csr_trap_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .csr_en         (csr_en),
    .csr_op         (csr_op),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .mret           (mret),
    .wfi            (wfi),
    .ext_irq        (ext_irq),
    .timer_irq      (timer_irq),
    .pc_exe         (pc_exe),
    .retire         (retire),
    .pipe_stall     (pipe_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .wfi_stall      (wfi_stall)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Architectural state of the model
  bit              m_mie, m_mpie, m_mtie, m_meie;
  logic [31:0]     m_mepc;
  longint unsigned m_cyc, m_ins;
  bit              m_sleep, m_busy;
  bit              exp_rv;
  logic [31:0]     exp_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0;
    m_mepc = '0; m_cyc = 0; m_ins = 0;
    m_sleep = 0; m_busy = 0; exp_rv = 0; exp_pc = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h304: return (32'(m_mtie) << 7) | (32'(m_meie) << 11);
      12'h305: return 32'h0001_0000;
      12'h341: return m_mepc;
      12'h344: return (32'(timer_irq) << 7) | (32'(ext_irq) << 11);
      12'hC00: return m_cyc[31:0];
      12'hC80: return m_cyc[63:32];
      12'hC02: return m_ins[31:0];
      12'hC82: return m_ins[63:32];
      default: return 32'h0;
    endcase
  endfunction

  // One clock of architectural behaviour, using the inputs currently driven.
  function automatic void model_cycle();
    bit wake, pend;
    logic [31:0] oldv, nv;
    wake = (ext_irq && m_meie) || (timer_irq && m_mtie);
    pend = m_mie && wake;
    m_cyc++;
    if (retire && !pipe_stall) m_ins++;
    exp_rv = 0;
    if (m_busy) begin
      m_busy = 0;
    end else if (m_sleep) begin
      if (wake) m_sleep = 0;
    end else if (!pipe_stall) begin
      if (pend) begin
        m_mepc = pc_exe & ~32'h3;
        m_mpie = m_mie;
        m_mie  = 0;
        exp_rv = 1; exp_pc = 32'h0001_0000; m_busy = 1;
      end else if (mret) begin
        m_mie  = m_mpie;
        m_mpie = 1;
        exp_rv = 1; exp_pc = m_mepc; m_busy = 1;
      end else if (wfi) begin
        m_sleep = 1;
      end else if (csr_en && csr_op != 2'b00) begin
        oldv = model_read(csr_addr);
        case (csr_op)
          2'b01:   nv = csr_wdata;
          2'b10:   nv = oldv | csr_wdata;
          default: nv = oldv & ~csr_wdata;
        endcase
        case (csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: begin m_mtie = nv[7]; m_meie = nv[11]; end
          12'h341: m_mepc = nv & ~32'h3;
          default: ;
        endcase
      end
    end
  endfunction

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_rv});
    chk("flush", {31'd0, flush}, {31'd0, exp_rv});
    chk("wfi_stall", {31'd0, wfi_stall}, {31'd0, m_sleep});
    if (exp_rv) chk("redirect_pc", redirect_pc, exp_pc);
    chk("csr_rdata", csr_rdata, model_read(csr_addr));
  endtask

  task automatic rd_const(input string tag, input logic [11:0] a, input logic [31:0] exp_v);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp_v);
  endtask

  logic [11:0] addr_tbl [10];

  initial begin
    addr_tbl = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h344,
                 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h123};
    csr_en = 0; mret = 0; wfi = 0; ext_irq = 0; timer_irq = 0; retire = 0; pipe_stall = 0;
    csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = '0; pc_exe = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_wfi_stall", {31'd0, wfi_stall}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    rst = 0;

    // Counters: 10 cycles of retire, 3 of them stalled
    retire = 1;
    for (int i = 0; i < 10; i++) begin
      pipe_stall = (i == 2 || i == 5 || i == 8);
      tick();
    end
    retire = 0; pipe_stall = 0;
    rd_const("cycle_lo", 12'hC00, 32'd10);
    rd_const("instret_lo", 12'hC02, 32'd7);
    rd_const("instret_hi", 12'hC82, 32'd0);

    // CSR read-modify-write ops
    csr_en = 1; csr_op = 2'b01; csr_addr = 12'h304; csr_wdata = 32'h880;
    tick();
    csr_op = 2'b11; csr_wdata = 32'h080;
    #1;
    chk("rc_old_mie", csr_rdata, 32'h880);
    tick();
    csr_en = 0;
    rd_const("mie_after_rc", 12'h304, 32'h800);
    csr_en = 1; csr_op = 2'b10; csr_addr = 12'h300; csr_wdata = 32'h8;
    tick();
    csr_en = 0;
    rd_const("mstatus_after_rs", 12'h300, 32'h1808);

    // Interrupt entry held off by stall
    pc_exe = 32'h200; ext_irq = 1; pipe_stall = 1;
    repeat (3) begin
      tick();
      chk("stalled_no_redirect", {31'd0, redirect_valid}, 32'd0);
    end
    pipe_stall = 0;
    tick();
    chk("trap_valid", {31'd0, redirect_valid}, 32'd1);
    chk("trap_flush", {31'd0, flush}, 32'd1);
    chk("trap_pc", redirect_pc, 32'h0001_0000);
    rd_const("trap_mepc", 12'h341, 32'h200);
    rd_const("trap_mstatus", 12'h300, 32'h1880);
    ext_irq = 0;
    tick();
    chk("trap_one_pulse", {31'd0, redirect_valid}, 32'd0);

    // MRET
    mret = 1;
    tick();
    mret = 0;
    chk("ret_valid", {31'd0, redirect_valid}, 32'd1);
    chk("ret_pc", redirect_pc, 32'h200);
    rd_const("ret_mstatus", 12'h300, 32'h1888);
    tick();

    // WFI with MIE=0, MTIE=1: wake without trapping
    csr_en = 1; csr_op = 2'b11; csr_addr = 12'h300; csr_wdata = 32'h8;
    tick();
    csr_op = 2'b10; csr_addr = 12'h304; csr_wdata = 32'h080;
    tick();
    csr_en = 0;
    wfi = 1;
    tick();
    wfi = 0;
    chk("wfi_enter", {31'd0, wfi_stall}, 32'd1);
    repeat (3) begin
      tick();
      chk("wfi_hold", {31'd0, wfi_stall}, 32'd1);
    end
    timer_irq = 1;
    tick();
    chk("wfi_wake", {31'd0, wfi_stall}, 32'd0);
    chk("wfi_wake_no_redirect", {31'd0, redirect_valid}, 32'd0);
    timer_irq = 0;
    tick();

    // Trap beats a simultaneous CSR write
    csr_en = 1; csr_op = 2'b10; csr_addr = 12'h300; csr_wdata = 32'h8;
    tick();
    csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'hDEAD_BEEC;
    ext_irq = 1; timer_irq = 1; pc_exe = 32'h300;
    tick();
    csr_en = 0;
    chk("prio_valid", {31'd0, redirect_valid}, 32'd1);
    chk("prio_pc", redirect_pc, 32'h0001_0000);
    rd_const("prio_mepc", 12'h341, 32'h300);
    ext_irq = 0; timer_irq = 0;
    tick();

    // Reset while sleeping
    wfi = 1;
    tick();
    wfi = 0;
    tick();
    chk("sleep_before_rst", {31'd0, wfi_stall}, 32'd1);
    rst = 1;
    #1;
    model_reset();
    chk("rst_sleep_wfi_stall", {31'd0, wfi_stall}, 32'd0);
    chk("rst_sleep_redirect", {31'd0, redirect_valid}, 32'd0);
    rd_const("rst_mstatus", 12'h300, 32'h1800);
    rd_const("rst_mie", 12'h304, 32'h0);
    rd_const("rst_mepc", 12'h341, 32'h0);
    rd_const("rst_instret", 12'hC02, 32'h0);
    @(posedge clk);
    #1;
    rst = 0;

    // Randomized traffic against the model
    csr_en = 1; csr_op = 2'b01; csr_addr = 12'h304; csr_wdata = 32'h880;
    tick();
    csr_op = 2'b10; csr_addr = 12'h300; csr_wdata = 32'h8;
    tick();
    csr_en = 0;
    for (int i = 0; i < 400; i++) begin
      int act;
      pipe_stall = ($urandom_range(0, 3) == 0);
      retire     = $urandom_range(0, 1);
      ext_irq    = ($urandom_range(0, 9) == 0);
      timer_irq  = ($urandom_range(0, 9) == 0);
      pc_exe     = $urandom & 32'hFFFF_FFFC;
      csr_addr   = addr_tbl[$urandom_range(0, 9)];
      csr_op     = 2'($urandom_range(0, 3));
      csr_wdata  = $urandom;
      act        = $urandom_range(0, 19);
      csr_en     = (act < 10);
      mret       = (act == 10);
      wfi        = (act == 11);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
